// File: rtl/rv32_ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type used by the
// rv32 AHB-Lite SRAM slave and its byte-lane decoder.
package rv32_ahb_lite_sram_slave_pkg;

    // HTRANS encodings
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic AHB_RESP_OKAY  = 1'b0;
    localparam logic AHB_RESP_ERROR = 1'b1;

    // HSIZE encodings supported by the slave
    localparam logic [2:0] AHB_SIZE_BYTE = 3'b000;
    localparam logic [2:0] AHB_SIZE_HALF = 3'b001;
    localparam logic [2:0] AHB_SIZE_WORD = 3'b010;

    // Data-phase state of the slave
    typedef enum logic [2:0] {
        DP_IDLE   = 3'd0,
        DP_READ   = 3'd1,
        DP_WRITE  = 3'd2,
        DP_WRHOLD = 3'd3,
        DP_ERR1   = 3'd4,
        DP_ERR2   = 3'd5
    } ahb_dphase_e;

endpackage

// File: rtl/rv32_ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between the interconnect/master and the SRAM slave.
//   master modport: drives address/control, HWDATA and the bus-level HREADY.
//   slave  modport: drives HRDATA, HREADYOUT and HRESP.
interface rv32_ahb_lite_sram_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/rv32_ahb_lite_sram_slave_byte_lane_decode.sv
// Little-endian byte-lane decoder for 32-bit AHB-Lite slaves.
//   hsize_i      : HSIZE of the transfer
//   addr_lo_i    : HADDR[1:0]
//   be_o         : byte enables (bit n = byte lane n)
//   misaligned_o : half-word on an odd address or word not on a word boundary
// Sizes above a word produce be_o = 0 and no misaligned flag; the caller
// rejects them separately.
module rv32_ahb_byte_lane_decode
    import rv32_ahb_lite_sram_slave_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o,
    output logic       misaligned_o
);

    always_comb begin
        be_o         = '0;
        misaligned_o = 1'b0;
        case (hsize_i)
            AHB_SIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
            AHB_SIZE_HALF: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            AHB_SIZE_WORD: begin
                be_o         = '1;
                misaligned_o = |addr_lo_i;
            end
            default: be_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32_ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a synchronous single-port SRAM (1-cycle read).
//   clk, rst_n   : clock, asynchronous active-low reset
//   ahb          : AHB-Lite slave port (HSEL..HREADY in, HRDATA/HREADYOUT/HRESP out)
//   sram_cs/we   : SRAM chip select / write enable
//   sram_addr    : SRAM word address
//   sram_be      : SRAM byte write enables
//   sram_wdata   : SRAM write data
//   sram_rdata   : SRAM read data, valid the cycle after a read select
// Reads hit the SRAM in the address phase; writes commit in the data phase
// when HWDATA is available. A read arriving during a write data phase is
// stalled one cycle because the single SRAM port is busy with the write.
module rv32_ahb_lite_sram_slave
    import rv32_ahb_lite_sram_slave_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned AW       = $clog2(MEM_BYTES) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32_ahb_lite_sram_slave_if.slave ahb,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [AW-1:0]         sram_addr,
    output logic [3:0]            sram_be,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    ahb_dphase_e   state_q, state_d;
    logic [AW-1:0] waddr_q;
    logic [3:0]    be_q;

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_be;
    logic          misaligned;
    logic          range_err;
    logic          size_err;
    logic          addr_err;
    logic          accept;
    logic          stall;

    rv32_ahb_byte_lane_decode u_lane (
        .hsize_i      (ahb.HSIZE),
        .addr_lo_i    (ahb.HADDR[1:0]),
        .be_o         (lane_be),
        .misaligned_o (misaligned)
    );

    // Unsigned offset wraps for addresses below BASE_ADDR, so one compare
    // covers both sides of the window.
    assign offset    = ahb.HADDR - BASE_ADDR;
    assign range_err = offset >= MEM_BYTES;
    assign size_err  = ahb.HSIZE > AHB_SIZE_WORD;
    assign addr_err  = range_err | size_err | misaligned;
    assign word_idx  = offset[AW+1:2];

    // Gating with rst_n keeps sram_cs low while reset is held.
    assign accept = rst_n & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    // Stall decision deliberately ignores HREADY so HREADYOUT has no
    // combinational path from it.
    assign stall = (state_q == DP_WRITE) & ahb.HSEL & ahb.HTRANS[1] & ~ahb.HWRITE;

    always_comb begin
        state_d = DP_IDLE;
        if (accept) begin
            if (addr_err)        state_d = DP_ERR1;
            else if (ahb.HWRITE) state_d = DP_WRITE;
            else                 state_d = DP_READ;
        end
        if (state_q == DP_ERR1) state_d = DP_ERR2;
        else if (stall)         state_d = DP_WRHOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DP_IDLE;
            waddr_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !addr_err && ahb.HWRITE) begin
                waddr_q <= word_idx;
                be_q    <= lane_be;
            end
        end
    end

    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;
        if (state_q == DP_WRITE) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = waddr_q;
            sram_be    = be_q;
            sram_wdata = ahb.HWDATA;
        end else if (accept && !addr_err && !ahb.HWRITE) begin
            sram_cs   = 1'b1;
            sram_addr = word_idx;
        end
    end

    assign ahb.HRDATA    = (state_q == DP_READ) ? sram_rdata : '0;
    assign ahb.HREADYOUT = ~((state_q == DP_ERR1) | stall);
    assign ahb.HRESP     = ((state_q == DP_ERR1) || (state_q == DP_ERR2)) ?
                           AHB_RESP_ERROR : AHB_RESP_OKAY;

endmodule

// File: tb/tb_rv32_ahb_lite_sram_slave.sv
// Directed testbench for rv32_ahb_lite_sram_slave with a behavioural SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge.
module tb_rv32_ahb_lite_sram_slave;
    import rv32_ahb_lite_sram_slave_pkg::*;

    localparam int unsigned MEM_BYTES = 65536;
    localparam int unsigned AW        = 14;

    logic          clk;
    logic          rst_n;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    rv32_ahb_lite_sram_slave_if bus ();

    // Single slave on the bus: HREADY is its own HREADYOUT.
    assign bus.HREADY = bus.HREADYOUT;

    rv32_ahb_lite_sram_slave #(
        .MEM_BYTES (MEM_BYTES),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ahb        (bus),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural synchronous SRAM, one-cycle read latency
    logic [31:0] mem [0:(MEM_BYTES/4)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        bus.HSEL   = sel;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
        bus.HADDR  = a;
        bus.HWDATA = wd;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] dpat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    logic [31:0] eaddr [4] = '{32'h0000_0102, 32'h0001_0000, 32'h0000_0101, 32'h0000_0100};
    logic [2:0]  esize [4] = '{AHB_SIZE_WORD, AHB_SIZE_WORD, AHB_SIZE_HALF, 3'b011};

    initial begin
        rst_n = 1'b0;
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        mid();
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(bus.HRESP),     32'h0);
        chk("rst_hrdata",    bus.HRDATA,         32'h0);
        chk("rst_cs",        32'(sram_cs),       32'h0);
        chk("rst_we",        32'(sram_we),       32'h0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // Word write 0x100, IDLE, read 0x100
        ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h100, 32'h0);
        mid(); chk("wr_ap_no_cs", 32'(sram_cs), 32'h0);
        nxt();
        ap(1'b1, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'hDEAD_BEEF);
        mid();
        chk("wr_dp_we",    32'(sram_we),        32'h1);
        chk("wr_dp_addr",  32'(sram_addr),      32'h40);
        chk("wr_dp_be",    32'(sram_be),        32'hF);
        chk("wr_dp_wdata", sram_wdata,          32'hDEAD_BEEF);
        chk("wr_dp_rdy",   32'(bus.HREADYOUT),  32'h1);
        nxt();
        ap(1'b1, AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h100, 32'h0);
        mid();
        chk("rd_ap_cs",    32'(sram_cs),        32'h1);
        chk("rd_ap_we",    32'(sram_we),        32'h0);
        chk("rd_ap_addr",  32'(sram_addr),      32'h40);
        chk("rd_ap_be",    32'(sram_be),        32'h0);
        chk("rd_ap_wdata", sram_wdata,          32'h0);
        chk("idle_dp_rdy", 32'(bus.HREADYOUT),  32'h1);
        chk("idle_dp_rsp", 32'(bus.HRESP),      32'h0);
        nxt();
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        mid();
        chk("rd_dp_data",  bus.HRDATA,          32'hDEAD_BEEF);
        chk("rd_dp_rdy",   32'(bus.HREADYOUT),  32'h1);
        nxt();
        mid(); chk("hrdata_idle_zero", bus.HRDATA, 32'h0);
        nxt();

        // Byte write 0xAA to 0x103, then read 0x100
        ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_BYTE, 32'h103, 32'h0);
        nxt();
        ap(1'b1, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'hAA00_0000);
        mid();
        chk("byte_be",    32'(sram_be), 32'h8);
        chk("byte_wdata", sram_wdata,   32'hAA00_0000);
        nxt();
        ap(1'b1, AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h100, 32'h0);
        nxt();
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        mid(); chk("byte_merge_rd", bus.HRDATA, 32'hAAAD_BEEF);
        nxt();

        // Write 0x200 immediately followed by read 0x200: one stall cycle
        ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h200, 32'h0);
        nxt();
        ap(1'b1, AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h200, 32'h1234_5678);
        mid();
        chk("raw_stall_rdy", 32'(bus.HREADYOUT), 32'h0);
        chk("raw_stall_we",  32'(sram_we),       32'h1);
        chk("raw_stall_adr", 32'(sram_addr),     32'h80);
        chk("raw_stall_wd",  sram_wdata,         32'h1234_5678);
        nxt();
        mid();
        chk("raw_hold_rdy",  32'(bus.HREADYOUT), 32'h1);
        chk("raw_hold_rsp",  32'(bus.HRESP),     32'h0);
        chk("raw_hold_cs",   32'(sram_cs),       32'h1);
        chk("raw_hold_we",   32'(sram_we),       32'h0);
        chk("raw_hold_adr",  32'(sram_addr),     32'h80);
        nxt();
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        mid();
        chk("raw_rd_data",   bus.HRDATA,         32'h1234_5678);
        chk("raw_rd_rdy",    32'(bus.HREADYOUT), 32'h1);
        nxt();

        // ERROR responses: misaligned word, out of range, odd half, bad size
        for (int e = 0; e < 4; e++) begin
            ap(1'b1, AHB_NONSEQ, 1'b0, esize[e], eaddr[e], 32'h0);
            mid(); chk($sformatf("err%0d_ap_cs", e), 32'(sram_cs), 32'h0);
            nxt();
            ap(1'b1, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
            mid();
            chk($sformatf("err%0d_c1_rdy", e), 32'(bus.HREADYOUT), 32'h0);
            chk($sformatf("err%0d_c1_rsp", e), 32'(bus.HRESP),     32'h1);
            chk($sformatf("err%0d_c1_cs",  e), 32'(sram_cs),       32'h0);
            nxt();
            mid();
            chk($sformatf("err%0d_c2_rdy", e), 32'(bus.HREADYOUT), 32'h1);
            chk($sformatf("err%0d_c2_rsp", e), 32'(bus.HRESP),     32'h1);
            chk($sformatf("err%0d_c2_cs",  e), 32'(sram_cs),       32'h0);
            nxt();
            mid(); chk($sformatf("err%0d_after_rsp", e), 32'(bus.HRESP), 32'h0);
            nxt();
        end

        // 16 back-to-back writes to 0x400.., then reads with BUSY / deselect
        for (int k = 0; k <= 16; k++) begin
            if (k < 16)
                ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h400 + 32'(4*k),
                   (k == 0) ? 32'h0 : dpat(k-1));
            else
                ap(1'b1, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, dpat(15));
            mid();
            if (k > 0) begin
                chk($sformatf("b2b_rdy%0d", k-1),  32'(bus.HREADYOUT), 32'h1);
                chk($sformatf("b2b_adr%0d", k-1),  32'(sram_addr),     32'h100 + 32'(k-1));
                chk($sformatf("b2b_wd%0d",  k-1),  sram_wdata,         dpat(k-1));
            end
            nxt();
        end
        for (int i = 0; i < 16; i++) begin
            ap(1'b1, AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h400 + 32'(4*i), 32'h0);
            mid();
            if (i > 0) begin
                chk($sformatf("gap_rdy%0d", i), 32'(bus.HREADYOUT), 32'h1);
                chk($sformatf("gap_rsp%0d", i), 32'(bus.HRESP),     32'h0);
            end
            nxt();
            if (i % 2 == 0)
                ap(1'b1, AHB_BUSY, 1'b0, AHB_SIZE_WORD, 32'h404, 32'h0);
            else
                ap(1'b0, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h400, 32'h0);
            mid();
            chk($sformatf("b2b_rd%0d", i),    bus.HRDATA,         dpat(i));
            chk($sformatf("b2b_rdrdy%0d", i), 32'(bus.HREADYOUT), 32'h1);
            chk($sformatf("gap_nocs%0d", i),  32'(sram_cs),       32'h0);
            nxt();
        end
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        mid();
        chk("last_gap_rdy", 32'(bus.HREADYOUT), 32'h1);
        chk("last_gap_rsp", 32'(bus.HRESP),     32'h0);
        nxt();

        // Reset in the middle of a write data phase
        ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h300, 32'h0);
        nxt();
        ap(1'b1, AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h300, 32'h1111_1111);
        nxt();
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h2222_2222);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_we",  32'(sram_we),       32'h0);
        chk("rstw_cs",  32'(sram_cs),       32'h0);
        chk("rstw_rdy", 32'(bus.HREADYOUT), 32'h1);
        nxt();
        rst_n = 1'b1;
        mid(); chk("rstw_rel_rdy", 32'(bus.HREADYOUT), 32'h1);
        nxt();
        ap(1'b1, AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h300, 32'h0);
        nxt();
        ap(1'b0, AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0, 32'h0);
        mid(); chk("rstw_word_kept", bus.HRDATA, 32'h1111_1111);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_ahb_lite_sram_slave.md
Name: rv32_ahb_lite_sram_slave

Overview:
- AHB-Lite slave (responder) that the RV32IM core's AHB-Lite master talks to.
- Decodes single NONSEQ transfers, drives a synchronous single-port SRAM macro (1-cycle read latency), and returns HRDATA/HREADYOUT/HRESP.
- Zero wait states except write-then-read port conflicts and ERROR responses.
- Sits between the SoC interconnect and the on-chip 65nm SRAM.

Parameters:
- MEM_BYTES, 65536: SRAM size in bytes; power of two, at least 8.
- BASE_ADDR, 32'h0000_0000: byte address of SRAM word 0; MEM_BYTES-aligned.
- AW, $clog2(MEM_BYTES)-2: SRAM word-address width (derived; not overridden).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write/read.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  AW  SRAM word address.
- sram_be  out  4  SRAM byte write enables.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after a read select.

Behaviour:
- Transfer accept: HSEL & HREADY & HTRANS[1]. SEQ is treated as NONSEQ. IDLE/BUSY with HSEL give an OKAY zero-wait data phase and no SRAM access.
- Address check on accept:
  - ERROR if HADDR-BASE_ADDR >= MEM_BYTES, HSIZE > 3'b010, half-word with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Byte enables are little-endian from HSIZE/HADDR[1:0]: byte = 1<<a[1:0]; half = 0011 or 1100; word = 1111.
- Data-phase FSM (registered state plus captured addr/be), states DP_IDLE, DP_READ, DP_WRITE, DP_WRHOLD, DP_ERR1, DP_ERR2:
  - DP_IDLE: HREADYOUT=1, HRESP=0.
  - Accepted read, address OK: sram_cs=1, sram_we=0, sram_addr=HADDR word index, all combinational in the address-phase cycle. Next state DP_READ.
  - DP_READ: HRDATA=sram_rdata, HREADYOUT=1, HRESP=0.
  - Accepted write, address OK: capture word address and be. Next state DP_WRITE. No SRAM access in the address phase.
  - DP_WRITE: sram_cs=1, sram_we=1, sram_addr=captured, sram_be=captured, sram_wdata=HWDATA.
    - If HSEL & HTRANS[1] & ~HWRITE this cycle (read would collide): HREADYOUT=0 and next state DP_WRHOLD.
    - Otherwise HREADYOUT=1.
  - DP_WRHOLD: write already committed; HREADYOUT=1, HRESP=0, no write. The pending read is accepted here and issued normally.
  - Accepted error transfer: no SRAM access, next state DP_ERR1.
  - DP_ERR1: HREADYOUT=0, HRESP=1; always goes to DP_ERR2.
  - DP_ERR2: HREADYOUT=1, HRESP=1.
- From DP_READ, DP_WRITE (not stalled), DP_WRHOLD and DP_ERR2, the next state follows the transfer accepted this cycle, else DP_IDLE.
- HRDATA is 0 outside DP_READ. sram_be=0 and sram_wdata=0 when sram_we=0.
- HREADYOUT must not depend combinationally on HREADY.
- Back-to-back writes: no stall; each write commits in its own data phase.
- Read after write to the same word: the stall orders the write first, so the read returns the new data.
- Transfers are ignored while HREADY=0, including ERR1 and the stalled write cycle.
- Reset (async, any state): state DP_IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, sram_cs=0, sram_we=0 immediately. A write whose data phase is cut by reset is not committed.

Decomposition:
- pkg_rv32_types gains:
  - ahb_dphase_e (the six states above).
  - AHB_IDLE, AHB_BUSY, AHB_SEQ alongside the existing AHB_NONSEQ.
  - AHB_RESP_OKAY/AHB_RESP_ERROR.
  - Reuses the existing AHB_SIZE_BYTE/HALF/WORD.
- Sub-module rv32_ahb_byte_lane_decode: combinational HSIZE + HADDR[1:0] -> be[3:0] and misaligned flag. Shareable with other slaves.

Test Plan:
- Reset mid-DP_WRITE (rst_n low during HWDATA phase) -> sram_we drops immediately, word unchanged, HREADYOUT=1 after release.
- Word write 0x100 = 0xDEADBEEF, then IDLE, then read 0x100 -> HRDATA=0xDEADBEEF in the read data phase with zero waits.
- Byte write 0xAA to 0x103 then read 0x100 -> sram_be=1000, read returns 0xAAADBEEF.
- Write 0x200 = 0x12345678 immediately followed by read 0x200 -> exactly one HREADYOUT=0 cycle, read returns 0x12345678.
- Word read at 0x102 or at BASE_ADDR+MEM_BYTES -> HREADYOUT/HRESP = (0,1) then (1,1), sram_cs never asserted.
- 16 back-to-back NONSEQ writes then 16 reads with HSEL toggling and BUSY interleaved -> no stalls on the write stream, all data matches, BUSY/IDLE give OKAY.
